// File: rtl/lion_mem_arbiter.sv
// Two-to-one round-robin arbiter sharing one native memory bus between
// instruction fetch and load/store, with an optional stall watchdog.
module lion_mem_arbiter #(
  parameter int unsigned TIMEOUT   = 64,
  parameter logic [31:0] ERR_RDATA = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        timeout,
  output logic        last_grant
);

  localparam int unsigned WD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
  localparam logic [WD_W-1:0] WD_MAX  = {WD_W{1'b1}};

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  state_t          state, state_n;
  logic [WD_W-1:0] wd, wd_n;
  logic            mem_valid_n, mem_instr_n, last_grant_n;
  logic [31:0]     mem_addr_n, mem_wdata_n;
  logic [3:0]      mem_wstrb_n;
  logic            wd_hit, done;
  logic [31:0]     rsp_data;

  // State and registered bus outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      wd         <= '0;
      mem_valid  <= 1'b0;
      mem_instr  <= 1'b0;
      mem_addr   <= 32'h0;
      mem_wdata  <= 32'h0;
      mem_wstrb  <= 4'h0;
      last_grant <= 1'b1;
    end else begin
      state      <= state_n;
      wd         <= wd_n;
      mem_valid  <= mem_valid_n;
      mem_instr  <= mem_instr_n;
      mem_addr   <= mem_addr_n;
      mem_wdata  <= mem_wdata_n;
      mem_wstrb  <= mem_wstrb_n;
      last_grant <= last_grant_n;
    end
  end

  // Arbitration, completion and watchdog; ready/rdata/timeout are combinational
  always_comb begin
    state_n      = state;
    wd_n         = wd;
    mem_valid_n  = mem_valid;
    mem_instr_n  = mem_instr;
    mem_addr_n   = mem_addr;
    mem_wdata_n  = mem_wdata;
    mem_wstrb_n  = mem_wstrb;
    last_grant_n = last_grant;
    i_ready      = 1'b0;
    i_rdata      = 32'h0;
    d_ready      = 1'b0;
    d_rdata      = 32'h0;
    timeout      = 1'b0;
    wd_hit       = (TIMEOUT != 0) && (wd == WD_LAST);
    done         = 1'b0;
    rsp_data     = mem_ready ? mem_rdata : ERR_RDATA;

    case (state)
      IDLE: begin
        // On contention the side that did not win last time is granted
        if (i_valid && (!d_valid || last_grant)) begin
          state_n      = BUSY_I;
          mem_valid_n  = 1'b1;
          mem_instr_n  = 1'b1;
          mem_addr_n   = i_addr;
          mem_wdata_n  = 32'h0;
          mem_wstrb_n  = 4'h0;
          last_grant_n = 1'b0;
          wd_n         = '0;
        end else if (d_valid) begin
          state_n      = BUSY_D;
          mem_valid_n  = 1'b1;
          mem_instr_n  = 1'b0;
          mem_addr_n   = d_addr;
          mem_wdata_n  = d_wdata;
          mem_wstrb_n  = d_wstrb;
          last_grant_n = 1'b1;
          wd_n         = '0;
        end
      end
      BUSY_I, BUSY_D: begin
        done    = mem_ready || wd_hit;
        timeout = !mem_ready && wd_hit;
        if (state == BUSY_I) begin
          i_ready = done;
          i_rdata = done ? rsp_data : 32'h0;
        end else begin
          d_ready = done;
          d_rdata = done ? rsp_data : 32'h0;
        end
        if (done) begin
          state_n     = IDLE;
          mem_valid_n = 1'b0;
          mem_wstrb_n = 4'h0;
        end else if (wd != WD_MAX) begin
          wd_n = wd + WD_W'(1);
        end
      end
      default: begin
        state_n     = IDLE;
        mem_valid_n = 1'b0;
        mem_wstrb_n = 4'h0;
      end
    endcase
  end

endmodule

// File: tb/tb_lion_mem_arbiter.sv
// Bench for lion_mem_arbiter: two instances (TIMEOUT=4 and default 64) on shared
// stimulus, checked every cycle against a transaction-level model plus directed literals.
module tb_lion_mem_arbiter;

  localparam logic [31:0] ERR0 = 32'hBAD0_BAD0;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_valid = 1'b0, d_valid = 1'b0, mem_ready = 1'b0;
  logic [31:0] i_addr = 32'h0, d_addr = 32'h0, d_wdata = 32'h0, mem_rdata = 32'h0;
  logic [3:0]  d_wstrb = 4'h0;

  logic        i_ready [2], d_ready [2], mem_valid [2], mem_instr [2];
  logic        timeout [2], last_grant [2];
  logic [31:0] i_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2];
  logic [3:0]  mem_wstrb [2];

  int n_tests = 0;
  int n_fail  = 0;
  int got;
  logic [5:0] instr_seq, lg_seq;

  always #5 clock = ~clock;

  lion_mem_arbiter #(.TIMEOUT(4), .ERR_RDATA(ERR0)) u_t4 (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready[0]), .i_rdata(i_rdata[0]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready[0]), .d_rdata(d_rdata[0]),
    .mem_valid(mem_valid[0]), .mem_instr(mem_instr[0]), .mem_ready(mem_ready),
    .mem_addr(mem_addr[0]), .mem_wdata(mem_wdata[0]), .mem_wstrb(mem_wstrb[0]),
    .mem_rdata(mem_rdata), .timeout(timeout[0]), .last_grant(last_grant[0])
  );

  lion_mem_arbiter u_t64 (
    .clock(clock), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready[1]), .i_rdata(i_rdata[1]),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready[1]), .d_rdata(d_rdata[1]),
    .mem_valid(mem_valid[1]), .mem_instr(mem_instr[1]), .mem_ready(mem_ready),
    .mem_addr(mem_addr[1]), .mem_wdata(mem_wdata[1]), .mem_wstrb(mem_wstrb[1]),
    .mem_rdata(mem_rdata), .timeout(timeout[1]), .last_grant(last_grant[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model: one outstanding transfer per instance, age = cycles on the bus so far
  typedef struct {
    bit          busy;
    bit          owner;   // 0 fetch, 1 data
    int          age;
    bit          last;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mdl_t;

  mdl_t m [2];

  function automatic int tmo(input int k);
    return (k == 0) ? 4 : 64;
  endfunction

  function automatic logic [31:0] err(input int k);
    return (k == 0) ? ERR0 : 32'h0;
  endfunction

  function automatic bit forced(input int k);
    return m[k].busy && !mem_ready && (tmo(k) != 0) && (m[k].age + 1 == tmo(k));
  endfunction

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m[k].busy = 1'b0; m[k].owner = 1'b0; m[k].age = 0; m[k].last = 1'b1;
        m[k].addr = 32'h0; m[k].wdata = 32'h0; m[k].wstrb = 4'h0;
      end else if (m[k].busy) begin
        if (mem_ready || forced(k)) begin
          m[k].busy  = 1'b0;
          m[k].wstrb = 4'h0;
        end else begin
          m[k].age++;
        end
      end else if (i_valid || d_valid) begin
        m[k].owner = (i_valid && d_valid) ? !m[k].last : d_valid;
        m[k].last  = m[k].owner;
        m[k].busy  = 1'b1;
        m[k].age   = 0;
        m[k].addr  = m[k].owner ? d_addr : i_addr;
        m[k].wdata = m[k].owner ? d_wdata : 32'h0;
        m[k].wstrb = m[k].owner ? d_wstrb : 4'h0;
      end
    end
  end

  // Per-cycle comparison of both instances against the model
  always @(negedge clock) begin
    for (int k = 0; k < 2; k++) begin
      bit fin;
      logic [31:0] rd;
      fin = m[k].busy && (mem_ready || forced(k));
      rd  = mem_ready ? mem_rdata : err(k);
      check($sformatf("mdl%0d mem_valid", k), 32'(mem_valid[k]), 32'(m[k].busy));
      check($sformatf("mdl%0d mem_wstrb", k), 32'(mem_wstrb[k]), 32'(m[k].wstrb));
      check($sformatf("mdl%0d last_grant", k), 32'(last_grant[k]), 32'(m[k].last));
      check($sformatf("mdl%0d i_ready", k), 32'(i_ready[k]), 32'(fin && !m[k].owner));
      check($sformatf("mdl%0d d_ready", k), 32'(d_ready[k]), 32'(fin && m[k].owner));
      check($sformatf("mdl%0d i_rdata", k), i_rdata[k], (fin && !m[k].owner) ? rd : 32'h0);
      check($sformatf("mdl%0d d_rdata", k), d_rdata[k], (fin && m[k].owner) ? rd : 32'h0);
      check($sformatf("mdl%0d timeout", k), 32'(timeout[k]), 32'(forced(k)));
      if (m[k].busy) begin
        check($sformatf("mdl%0d mem_instr", k), 32'(mem_instr[k]), 32'(!m[k].owner));
        check($sformatf("mdl%0d mem_addr", k), mem_addr[k], m[k].addr);
        check($sformatf("mdl%0d mem_wdata", k), mem_wdata[k], m[k].wdata);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    reset = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
  endtask

  task automatic wait_mv(input int k, input string name);
    int n = 0;
    while (!mem_valid[k] && n < 20) begin
      step();
      n++;
    end
    check({name, " grant_seen"}, 32'(mem_valid[k]), 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    #1;
    do_reset();
    check("rst mem_valid", 32'(mem_valid[1]), 32'd0);
    check("rst mem_instr", 32'(mem_instr[1]), 32'd0);
    check("rst mem_addr", mem_addr[1], 32'h0);
    check("rst mem_wdata", mem_wdata[1], 32'h0);
    check("rst last_grant", 32'(last_grant[1]), 32'd1);

    // Fetch only, mem_ready two cycles after mem_valid
    i_valid = 1'b1; i_addr = 32'h100;
    wait_mv(1, "fetch");
    check("fetch mem_instr", 32'(mem_instr[1]), 32'd1);
    check("fetch mem_addr", mem_addr[1], 32'h100);
    check("fetch mem_wstrb", 32'(mem_wstrb[1]), 32'h0);
    step(); step();
    mem_ready = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    check("fetch i_ready", 32'(i_ready[1]), 32'd1);
    check("fetch i_rdata", i_rdata[1], 32'hDEAD_BEEF);
    check("fetch d_ready", 32'(d_ready[1]), 32'd0);
    step();
    i_valid = 1'b0; mem_ready = 1'b0;
    check("fetch drop", 32'(mem_valid[1]), 32'd0);

    // Contention after reset: fetch first, store follows two cycles after ready
    do_reset();
    i_valid = 1'b1; i_addr = 32'h180;
    d_valid = 1'b1; d_addr = 32'h200; d_wdata = 32'h1234_5678; d_wstrb = 4'hF;
    wait_mv(1, "cont");
    check("cont first instr", 32'(mem_instr[1]), 32'd1);
    check("cont first addr", mem_addr[1], 32'h180);
    mem_ready = 1'b1; mem_rdata = 32'h11;
    #1;
    check("cont i_ready", 32'(i_ready[1]), 32'd1);
    step();
    i_valid = 1'b0; mem_ready = 1'b0;
    check("cont gap", 32'(mem_valid[1]), 32'd0);
    step();
    check("cont store valid", 32'(mem_valid[1]), 32'd1);
    check("cont store instr", 32'(mem_instr[1]), 32'd0);
    check("cont store addr", mem_addr[1], 32'h200);
    check("cont store wdata", mem_wdata[1], 32'h1234_5678);
    check("cont store wstrb", 32'(mem_wstrb[1]), 32'hF);
    mem_ready = 1'b1; mem_rdata = 32'h22;
    #1;
    check("cont d_rdata", d_rdata[1], 32'h22);
    step();
    d_valid = 1'b0; mem_ready = 1'b0;

    // Round robin with both requesters always valid
    do_reset();
    i_valid = 1'b1; i_addr = 32'h300;
    d_valid = 1'b1; d_addr = 32'h304; d_wdata = 32'h0; d_wstrb = 4'h0;
    mem_ready = 1'b1; mem_rdata = 32'h5;
    got = 0; instr_seq = '0; lg_seq = '0;
    for (int c = 0; c < 40 && got < 6; c++) begin
      step();
      if (mem_valid[1]) begin
        instr_seq[got] = mem_instr[1];
        lg_seq[got]    = last_grant[1];
        got++;
      end
    end
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;
    check("rr count", 32'(got), 32'd6);
    check("rr instr seq", 32'(instr_seq), 32'(6'b010101));
    check("rr last_grant seq", 32'(lg_seq), 32'(6'b101010));

    // Watchdog expiry on the 4th bus cycle (TIMEOUT=4 instance)
    do_reset();
    d_valid = 1'b1; d_addr = 32'h400; d_wstrb = 4'h0; mem_rdata = 32'h77;
    wait_mv(0, "tmo");
    step(); step(); step();
    check("tmo d_ready", 32'(d_ready[0]), 32'd1);
    check("tmo d_rdata", d_rdata[0], ERR0);
    check("tmo pulse", 32'(timeout[0]), 32'd1);
    check("tmo t64 quiet", 32'(d_ready[1]), 32'd0);
    step();
    d_valid = 1'b0;
    check("tmo release", 32'(mem_valid[0]), 32'd0);
    check("tmo pulse end", 32'(timeout[0]), 32'd0);

    // mem_ready in the expiry cycle wins
    do_reset();
    d_valid = 1'b1; d_addr = 32'h404;
    wait_mv(0, "tmo2");
    step(); step(); step();
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_F00D;
    #1;
    check("tmo2 d_ready", 32'(d_ready[0]), 32'd1);
    check("tmo2 d_rdata", d_rdata[0], 32'hCAFE_F00D);
    check("tmo2 no pulse", 32'(timeout[0]), 32'd0);
    step();
    d_valid = 1'b0; mem_ready = 1'b0;

    // Reset in the middle of a store; fetch wins the next contest
    do_reset();
    d_valid = 1'b1; d_addr = 32'h500; d_wdata = 32'h55; d_wstrb = 4'h1;
    wait_mv(1, "mrst");
    step();
    i_valid = 1'b1; i_addr = 32'h600;
    #2;
    reset = 1'b1; mem_ready = 1'b1;
    #1;
    check("mrst mem_valid", 32'(mem_valid[1]), 32'd0);
    check("mrst d_ready", 32'(d_ready[1]), 32'd0);
    check("mrst mem_wstrb", 32'(mem_wstrb[1]), 32'h0);
    check("mrst last_grant", 32'(last_grant[1]), 32'd1);
    step();
    mem_ready = 1'b0; reset = 1'b0;
    wait_mv(1, "mrst regrant");
    check("mrst fetch first", 32'(mem_instr[1]), 32'd1);
    check("mrst fetch addr", mem_addr[1], 32'h600);
    mem_ready = 1'b1; mem_rdata = 32'h66;
    #1;
    check("mrst i_ready", 32'(i_ready[1]), 32'd1);
    step();
    i_valid = 1'b0; d_valid = 1'b0; mem_ready = 1'b0;

    // Payload held while inputs change during a long store
    do_reset();
    d_valid = 1'b1; d_addr = 32'h700; d_wdata = 32'hA5A5_A5A5; d_wstrb = 4'h3;
    wait_mv(1, "hold");
    for (int c = 0; c < 10; c++) begin
      i_addr = 32'h1000 + 32'(c);
      d_addr = ~d_addr;
      step();
      check("hold mem_addr", mem_addr[1], 32'h700);
      check("hold mem_wdata", mem_wdata[1], 32'hA5A5_A5A5);
      check("hold mem_wstrb", 32'(mem_wstrb[1]), 32'h3);
    end
    mem_ready = 1'b1; mem_rdata = 32'h99;
    #1;
    check("hold d_ready", 32'(d_ready[1]), 32'd1);
    check("hold d_rdata", d_rdata[1], 32'h99);
    step();
    d_valid = 1'b0; mem_ready = 1'b0;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
